wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Parametrised writeback observation port for the MIPS pipeline. It sits beside the register-file write port. It captures every architecturally visible writeback as a (register, value) pair into a DEPTH-entry FIFO and presents the pairs to a board/test consumer over a valid/ready handshake. Unlike a plain gated output, it survives consumer stalls, reports lost writebacks, and zeroes its data outputs whenever nothing is valid.

## Interface
- DATA_W, 32, writeback data width
- REG_AW, 5, destination register index width
- DEPTH, 8, FIFO entries; power of two, at least 2
- DROP_R0, 1, when 1, writebacks to register 0 are not captured
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- reg_write  in  1  writeback-stage write enable
- write_reg  in  REG_AW  writeback destination register
- result  in  DATA_W  writeback value
- clear  in  1  synchronous flush of FIFO and status
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head this cycle
- out_reg  out  REG_AW  head register index; 0 when out_valid=0
- out_data  out  DATA_W  head value; 0 when out_valid=0
- count  out  log2(DEPTH)+1  entries currently held
- overflow  out  1  sticky: at least one capture was dropped
- drop_cnt  out  16  dropped captures, saturating

## Operation
- Capture condition (cap): reg_write=1, and not (DROP_R0=1 and write_reg=0).
- Pop condition (pop): out_valid=1 and out_ready=1.
- Push when cap=1 and either count<DEPTH or pop=1 in the same cycle. A full FIFO with a simultaneous pop accepts the new entry and count is unchanged.
- Drop when cap=1, count=DEPTH and pop=0:
  - The entry is discarded and the FIFO is unchanged.
  - overflow is set.
  - drop_cnt increments and saturates at 16'hFFFF.
- Storage: circular buffer with read and write pointers of log2(DEPTH) bits. Pointers wrap modulo DEPTH. Full and empty are derived from count.
- Output ordering: first-word-fall-through. out_reg and out_data show the head entry directly from storage.
- Output zeroing: when empty, out_valid=0 and out_reg and out_data are forced to 0.
- Priority: clear beats push and pop.
  - In a clear cycle, count goes to 0, pointers go to 0, overflow goes to 0 and drop_cnt goes to 0.
  - A capture in the same cycle is discarded and is not counted as a drop.
- Bus stability: out_reg and out_data must not change while out_valid=1 and out_ready=0, unless clear is asserted.

## Timing
- Reset (rst_n=0, asynchronous) drives the following, with no clock required:
  - out_valid=0, out_reg=0, out_data=0
  - count=0, overflow=0, drop_cnt=0
  - pointers=0
- Storage contents need not be reset.
- Capture-to-output latency: 1 cycle. A capture at edge N into an empty FIFO gives out_valid=1 after edge N.
- Pop takes effect at the edge where out_valid and out_ready are both 1. The next entry, or zeros, appears after that edge.
- Throughput: one push and one pop per cycle sustained. Count is steady under simultaneous push and pop.
- Empty with cap and out_ready in the same cycle: no pop, because out_valid=0. The entry appears next cycle.
- count, overflow and drop_cnt are registered and update at the same edge as the event that changes them.

## Test plan
- Reset then a single capture:
  - Stimulus: rst_n low mid-traffic, release, then reg_write=1, write_reg=5, result=32'hDEADBEEF for one cycle with out_ready=0.
  - Required: all outputs 0 during reset; one cycle later out_valid=1, out_reg=5, out_data=32'hDEADBEEF, count=1.
  - Then raise out_ready: after one edge out_valid=0, out_data=0.
- Register-0 filter:
  - Stimulus: write_reg=0, reg_write=1 with DROP_R0=1.
  - Required: count stays 0.
  - With DROP_R0=0, the same stimulus gives count=1 and out_reg=0.
- Fill and overflow (DEPTH=8):
  - Stimulus: 10 captures with values 1..10 and out_ready=0.
  - Required: count=8, overflow=1, drop_cnt=2.
  - Draining yields values 1..8 in order, with wrap exercised by a second fill.
- Full with simultaneous pop:
  - Stimulus: FIFO full, cap and out_ready both 1 for 4 cycles.
  - Required: count stays 8, drop_cnt unchanged, output order preserved.
- Clear priority:
  - Stimulus: 3 entries, overflow=1, then clear=1 together with a capture.
  - Required: next cycle count=0, out_valid=0, overflow=0, drop_cnt=0, and the captured value never appears.
- Saturation:
  - Stimulus: hold the FIFO full and capture 70000 times.
  - Required: drop_cnt=16'hFFFF and it does not wrap.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: captures (register, value) writeback pairs into a
// first-word-fall-through FIFO with drop accounting and a valid/ready drain port.
module wb_trace_buffer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DROP_R0 = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       reg_write,
    input  logic [REG_AW-1:0]          write_reg,
    input  logic [DATA_W-1:0]          result,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [REG_AW-1:0]          out_reg,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [REG_AW-1:0] r_reg_mem  [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic [15:0]       r_drop_cnt;

    logic w_cap;
    logic w_full;
    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_cap   = reg_write && !((DROP_R0 != 0) && (write_reg == '0));
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && out_ready;
    assign w_push  = w_cap && (!w_full || w_pop) && !clear;
    assign w_drop  = w_cap && w_full && !w_pop && !clear;

    // Storage payload is not reset; only the head is ever exposed, and only when valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg_mem[r_wptr]  <= write_reg;
            r_data_mem[r_wptr] <= result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Drop counter saturates rather than wrapping.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    assign out_valid = w_valid;
    assign out_reg   = w_valid ? r_reg_mem[r_rptr]  : '0;
    assign out_data  = w_valid ? r_data_mem[r_rptr] : '0;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (DEPTH=8), with a second
// instance built without the register-0 filter.
module tb_wb_trace_buffer;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] result;
    logic        clear;
    logic        out_ready;

    logic        out_valid,  out_valid2;
    logic [4:0]  out_reg,    out_reg2;
    logic [31:0] out_data,   out_data2;
    logic [3:0]  count,      count2;
    logic        overflow,   overflow2;
    logic [15:0] drop_cnt,   drop_cnt2;

    int total;
    int bad;

    wb_trace_buffer #(.DATA_W(32), .REG_AW(5), .DEPTH(8), .DROP_R0(1)) dut (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_reg(write_reg),
        .result(result), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_reg(out_reg), .out_data(out_data), .count(count), .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    wb_trace_buffer #(.DATA_W(32), .REG_AW(5), .DEPTH(8), .DROP_R0(0)) dut_r0 (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_reg(write_reg),
        .result(result), .clear(clear), .out_valid(out_valid2), .out_ready(out_ready),
        .out_reg(out_reg2), .out_data(out_data2), .count(count2), .overflow(overflow2),
        .drop_cnt(drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs and checks happen 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; clear = 1'b0; out_ready = 1'b0;
        reg_write = 1'b1; write_reg = 5'd3; result = 32'h1111;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", out_valid); end
        total++; if (out_reg !== 5'd0) begin bad++; $display("FAIL rst_reg got=%0h exp=0", out_reg); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL rst_data got=%0h exp=0", out_data); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0h exp=0", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0h exp=0", overflow); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_drop got=%0h exp=0", drop_cnt); end
        reg_write = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        reg_write = 1'b1; write_reg = 5'd5; result = 32'hDEADBEEF;
        step();
        reg_write = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h exp=1", out_valid); end
        total++; if (out_reg !== 5'd5) begin bad++; $display("FAIL single_reg got=%0h exp=5", out_reg); end
        total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%0h exp=deadbeef", out_data); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count got=%0h exp=1", count); end
        step();
        total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_hold got=%0h exp=deadbeef", out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pop_valid got=%0h exp=0", out_valid); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL pop_data got=%0h exp=0", out_data); end
        total++; if (out_reg !== 5'd0) begin bad++; $display("FAIL pop_reg got=%0h exp=0", out_reg); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL pop_count got=%0h exp=0", count); end
    endtask

    task automatic test_r0_filter();
        clear = 1'b1;
        step();
        clear = 1'b0;
        reg_write = 1'b1; write_reg = 5'd0; result = 32'h123;
        step();
        reg_write = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL r0_drop_count got=%0h exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL r0_drop_valid got=%0h exp=0", out_valid); end
        total++; if (count2 !== 4'd1) begin bad++; $display("FAIL r0_keep_count got=%0h exp=1", count2); end
        total++; if (out_valid2 !== 1'b1) begin bad++; $display("FAIL r0_keep_valid got=%0h exp=1", out_valid2); end
        total++; if (out_reg2 !== 5'd0) begin bad++; $display("FAIL r0_keep_reg got=%0h exp=0", out_reg2); end
        total++; if (out_data2 !== 32'h123) begin bad++; $display("FAIL r0_keep_data got=%0h exp=123", out_data2); end
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_fill_overflow();
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            reg_write = 1'b1; write_reg = 5'(i); result = 32'(i);
            step();
            total++; if (out_data !== 32'd1) begin bad++; $display("FAIL fill_hold_%0d got=%0h exp=1", i, out_data); end
        end
        reg_write = 1'b0;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0h exp=8", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_overflow got=%0h exp=1", overflow); end
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL fill_drop got=%0h exp=2", drop_cnt); end
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total++; if (out_data !== 32'(i)) begin bad++; $display("FAIL drain_%0d got=%0h exp=%0h", i, out_data, i); end
            total++; if (out_reg !== 5'(i)) begin bad++; $display("FAIL drain_reg_%0d got=%0h exp=%0h", i, out_reg, i); end
            step();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0h exp=0", out_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%0h exp=1", overflow); end
        // Offset pointers by 3 so the next full fill wraps.
        for (int i = 0; i < 3; i++) begin
            reg_write = 1'b1; write_reg = 5'd7; result = 32'(100 + i);
            step();
        end
        reg_write = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        out_ready = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL offset_count got=%0h exp=0", count); end
        for (int i = 0; i < 8; i++) begin
            reg_write = 1'b1; write_reg = 5'd9; result = 32'(200 + i);
            step();
        end
        reg_write = 1'b0;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL wrap_count got=%0h exp=8", count); end
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL wrap_drop got=%0h exp=2", drop_cnt); end
        total++; if (out_data !== 32'd200) begin bad++; $display("FAIL wrap_head got=%0h exp=c8", out_data); end
    endtask

    task automatic test_full_simultaneous();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++; if (out_data !== 32'(200 + k)) begin bad++; $display("FAIL fullpop_head_%0d got=%0h exp=%0h", k, out_data, 200 + k); end
            reg_write = 1'b1; write_reg = 5'd11; result = 32'(300 + k);
            step();
            total++; if (count !== 4'd8) begin bad++; $display("FAIL fullpop_count_%0d got=%0h exp=8", k, count); end
        end
        reg_write = 1'b0;
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL fullpop_drop got=%0h exp=2", drop_cnt); end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (out_data !== ((k < 4) ? 32'(204 + k) : 32'(296 + k))) begin
                bad++; $display("FAIL fullpop_order_%0d got=%0h", k, out_data);
            end
            step();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%0h exp=0", out_valid); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) begin
            reg_write = 1'b1; write_reg = 5'd4; result = 32'hA1 + 32'(i);
            step();
        end
        total++; if (count !== 4'd3) begin bad++; $display("FAIL clr_pre_count got=%0h exp=3", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr_pre_overflow got=%0h exp=1", overflow); end
        clear = 1'b1; reg_write = 1'b1; write_reg = 5'd6; result = 32'hBAD;
        step();
        clear = 1'b0; reg_write = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL clr_count got=%0h exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%0h exp=0", out_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_overflow got=%0h exp=0", overflow); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL clr_drop got=%0h exp=0", drop_cnt); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (out_data !== 32'd0) begin bad++; $display("FAIL clr_ghost_%0d got=%0h exp=0", k, out_data); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            reg_write = 1'b1; write_reg = 5'd2; result = 32'(500 + i);
            step();
        end
        for (int i = 0; i < 70000; i++) begin
            result = 32'(1000 + i);
            step();
        end
        reg_write = 1'b0;
        total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_drop got=%0h exp=ffff", drop_cnt); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sat_overflow got=%0h exp=1", overflow); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL sat_count got=%0h exp=8", count); end
        total++; if (out_data !== 32'd500) begin bad++; $display("FAIL sat_head got=%0h exp=1f4", out_data); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
        reg_write = 1'b0; write_reg = '0; result = '0;
        #12 rst_n = 1'b1;
        test_reset();
        test_r0_filter();
        test_fill_overflow();
        test_full_simultaneous();
        test_clear();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
